// File: rtl/mem_pkg.sv
// Shared definitions for the 256-byte memory burst master: widths, command opcodes and FSM states.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        OP_COPY = 2'b00,
        OP_FILL = 2'b01,
        OP_SUM  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StFill,
        StSum,
        StDone
    } state_e;

endpackage

// File: rtl/mem_burst_master.sv
// Command-driven initiator for a single-port byte memory: COPY, FILL and SUM bursts with one
// access per cycle and fully registered memory-side outputs.
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_fill,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] sum,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [DATA_W-1:0] mem_write_in,
    input  logic [DATA_W-1:0] mem_read_out
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d, re_q, re_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [LEN_W-1:0]  len_eff;
    logic [LEN_W-1:0]  idx_nxt;
    logic              last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sum_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            re_q    <= re_d;
            wdata_q <= wdata_d;
        end
    end

    // Strobes are computed one cycle ahead so they appear registered in the cycle they apply to.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        wdata_d = wdata_q;
        len_eff = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
        idx_nxt = idx_q + 1'b1;
        last    = (idx_nxt >= len_q);

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    src_d  = cmd_src;
                    dst_d  = cmd_dst;
                    len_d  = len_eff;
                    fill_d = cmd_fill;
                    idx_d  = '0;
                    sum_d  = '0;
                    busy_d = 1'b1;
                    err_d  = (op_e'(cmd_op) == OP_RSVD);
                    if (len_eff == '0 || op_e'(cmd_op) == OP_RSVD) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        case (op_e'(cmd_op))
                            OP_COPY: begin
                                state_d = StRd;
                                re_d    = 1'b1;
                                addr_d  = cmd_src;
                            end
                            OP_FILL: begin
                                state_d = StFill;
                                we_d    = 1'b1;
                                addr_d  = cmd_dst;
                                wdata_d = cmd_fill;
                            end
                            default: begin
                                state_d = StSum;
                                re_d    = 1'b1;
                                addr_d  = cmd_src;
                            end
                        endcase
                    end
                end
            end
            StRd: begin
                state_d = StWr;
                we_d    = 1'b1;
                addr_d  = dst_q + idx_q[ADDR_W-1:0];
                wdata_d = mem_read_out;
            end
            StWr: begin
                idx_d = idx_nxt;
                if (last) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StRd;
                    re_d    = 1'b1;
                    addr_d  = src_q + idx_nxt[ADDR_W-1:0];
                end
            end
            StFill: begin
                idx_d = idx_nxt;
                if (last) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = dst_q + idx_nxt[ADDR_W-1:0];
                    wdata_d = fill_q;
                end
            end
            StSum: begin
                idx_d = idx_nxt;
                sum_d = sum_q + mem_read_out;
                if (last) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    re_d   = 1'b1;
                    addr_d = src_q + idx_nxt[ADDR_W-1:0];
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign cmd_ready    = (state_q == StIdle);
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign sum          = sum_q;
    assign mem_addr     = addr_q;
    assign mem_write_en = we_q;
    assign mem_read_en  = re_q;
    assign mem_write_in = wdata_q;

endmodule
